// File: rtl/basis_modulator_nd_if.sv
// Symbol handshake, basis-table load port and DAC sample stream of basis_modulator_nd.
// master = symbol/coefficient source, slave = modulator.
interface basis_modulator_nd_if #(
  parameter int NUM_DIM    = 3,
  parameter int AMP_WIDTH  = 2,
  parameter int IDX_WIDTH  = 4,
  parameter int COEF_WIDTH = 12,
  parameter int DAC_WIDTH  = 12
);
  localparam int DSEL_W = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1;

  logic                           sym_valid;
  logic                           sym_ready;
  logic [NUM_DIM*AMP_WIDTH-1:0]   sym_data;
  logic                           coef_we;
  logic [DSEL_W-1:0]              coef_dim;
  logic [IDX_WIDTH-1:0]           coef_addr;
  logic [COEF_WIDTH-1:0]          coef_wdata;
  logic [DAC_WIDTH-1:0]           out_sample;
  logic                           out_valid;
  logic                           underrun;
  logic                           underrun_clr;

  modport master (
    output sym_valid, sym_data, coef_we, coef_dim, coef_addr, coef_wdata, underrun_clr,
    input  sym_ready, out_sample, out_valid, underrun
  );

  modport slave (
    input  sym_valid, sym_data, coef_we, coef_dim, coef_addr, coef_wdata, underrun_clr,
    output sym_ready, out_sample, out_valid, underrun
  );
endinterface

// File: rtl/basis_modulator_nd.sv
// N-dimensional basis-waveform modulator: per-dimension antipodal levels scale
// loadable basis tables, summed, shifted, offset and saturated into DAC codes.
module basis_modulator_nd #(
  parameter int NUM_DIM     = 3,
  parameter int AMP_WIDTH   = 2,
  parameter int SPS         = 10,
  parameter int IDX_WIDTH   = 4,
  parameter int COEF_WIDTH  = 12,
  parameter int DAC_WIDTH   = 12,
  parameter int OUT_SHIFT   = 2,
  parameter int ZERO_OFFSET = 2048
) (
  input  logic                clk,
  input  logic                rst,
  basis_modulator_nd_if.slave bus
);
  localparam int SYM_W  = NUM_DIM * AMP_WIDTH;
  localparam int DSEL_W = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1;
  localparam int LVL_W  = AMP_WIDTH + 1;
  localparam int PROD_W = COEF_WIDTH + AMP_WIDTH + 1;
  localparam int SUM_W  = PROD_W + ((NUM_DIM > 1) ? $clog2(NUM_DIM) : 0);
  localparam int OFS_W  = ((SUM_W > DAC_WIDTH + 1) ? SUM_W : DAC_WIDTH + 1) + 1;

  localparam logic [IDX_WIDTH-1:0]    LAST_IDX  = IDX_WIDTH'(SPS - 1);
  localparam logic [DAC_WIDTH-1:0]    ZERO_CODE = DAC_WIDTH'(ZERO_OFFSET);
  localparam logic signed [OFS_W-1:0] OFS_ZERO  = OFS_W'(ZERO_OFFSET);
  localparam logic signed [OFS_W-1:0] OFS_MAX   = OFS_W'((2 ** DAC_WIDTH) - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Code k -> 2k+1-2^A: append a 1 and flip the MSB of the (A+1)-bit result.
  function automatic logic signed [LVL_W-1:0] amp_level(input logic [AMP_WIDTH-1:0] code);
    logic [LVL_W-1:0] t;
    t            = {code, 1'b1};
    t[LVL_W-1]   = ~t[LVL_W-1];
    return $signed(t);
  endfunction

  state_t                  state_r, state_s;
  logic [SYM_W-1:0]        cur_r, hold_r;
  logic                    hold_full_r;
  logic [IDX_WIDTH-1:0]    idx_r;
  logic                    underrun_r;
  logic signed [COEF_WIDTH-1:0] coef_mem_r [NUM_DIM][SPS];

  logic accept_s, last_s, coef_ok_s;
  logic cur_load_s, cur_from_hold_s, hold_load_s, hold_clear_s;
  logic idx_clear_s, idx_inc_s, underrun_set_s, issue_s;

  logic                         s0_valid_r, s1_valid_r, s2_valid_r, out_valid_r;
  logic [IDX_WIDTH-1:0]         s0_idx_r;
  logic [SYM_W-1:0]             s0_code_r;
  logic signed [COEF_WIDTH-1:0] s1_coef_r [NUM_DIM];
  logic signed [LVL_W-1:0]      s1_lvl_r  [NUM_DIM];
  logic signed [PROD_W-1:0]     s2_prod_r [NUM_DIM];
  logic [DAC_WIDTH-1:0]         out_sample_r;

  logic signed [SUM_W-1:0] sum_s, shift_s;
  logic signed [OFS_W-1:0] biased_s;
  logic [DAC_WIDTH-1:0]    clamp_s;

  assign accept_s  = bus.sym_valid & ~hold_full_r;
  assign last_s    = (idx_r == LAST_IDX);
  assign coef_ok_s = bus.coef_we
                   & ({1'b0, bus.coef_dim}  < (DSEL_W + 1)'(NUM_DIM))
                   & ({1'b0, bus.coef_addr} < (IDX_WIDTH + 1)'(SPS));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_RUN;
        else          state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s && !hold_full_r && !accept_s) state_s = ST_IDLE;
        else                                     state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: sequencing strobes for cur, hold, idx and underrun
  always_comb begin
    cur_load_s      = 1'b0;
    cur_from_hold_s = 1'b0;
    hold_load_s     = 1'b0;
    hold_clear_s    = 1'b0;
    idx_clear_s     = 1'b0;
    idx_inc_s       = 1'b0;
    underrun_set_s  = 1'b0;
    issue_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idx_clear_s = 1'b1;
        if (accept_s) cur_load_s = 1'b1;
        else          cur_load_s = 1'b0;
      end
      ST_RUN: begin
        issue_s = 1'b1;
        if (last_s) begin
          idx_clear_s = 1'b1;
          if (hold_full_r) begin
            cur_load_s      = 1'b1;
            cur_from_hold_s = 1'b1;
            hold_clear_s    = 1'b1;
          end else if (accept_s) begin
            cur_load_s      = 1'b1;
          end else begin
            underrun_set_s  = 1'b1;
          end
        end else begin
          idx_inc_s   = 1'b1;
          hold_load_s = accept_s;
        end
      end
      default: idx_clear_s = 1'b1;
    endcase
  end

  // Symbol registers, sample index and sticky underrun (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r       <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      idx_r       <= '0;
      underrun_r  <= 1'b0;
    end else begin
      if (cur_load_s) cur_r <= cur_from_hold_s ? hold_r : bus.sym_data;
      if (hold_load_s) begin
        hold_r      <= bus.sym_data;
        hold_full_r <= 1'b1;
      end else if (hold_clear_s) begin
        hold_full_r <= 1'b0;
      end
      if (idx_clear_s)    idx_r <= '0;
      else if (idx_inc_s) idx_r <= idx_r + IDX_WIDTH'(1);
      underrun_r <= underrun_set_s | (underrun_r & ~bus.underrun_clr);
    end
  end

  // Basis tables: not reset; a same-edge read sees the previous contents
  always_ff @(posedge clk) begin
    if (coef_ok_s) coef_mem_r[bus.coef_dim][bus.coef_addr] <= $signed(bus.coef_wdata);
  end

  // Pipeline S0 (issue) -> S1 (table read) -> S2 (scale) -> output
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_r   <= 1'b0;
      s0_idx_r     <= '0;
      s0_code_r    <= '0;
      s1_valid_r   <= 1'b0;
      s2_valid_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_sample_r <= ZERO_CODE;
      for (int d = 0; d < NUM_DIM; d++) begin
        s1_coef_r[d] <= '0;
        s1_lvl_r[d]  <= '0;
        s2_prod_r[d] <= '0;
      end
    end else begin
      s0_valid_r <= issue_s;
      s0_idx_r   <= idx_r;
      s0_code_r  <= cur_r;
      s1_valid_r <= s0_valid_r;
      s2_valid_r <= s1_valid_r;
      for (int d = 0; d < NUM_DIM; d++) begin
        s1_coef_r[d] <= coef_mem_r[d][s0_idx_r];
        s1_lvl_r[d]  <= amp_level(s0_code_r[d*AMP_WIDTH +: AMP_WIDTH]);
        s2_prod_r[d] <= PROD_W'(s1_coef_r[d]) * PROD_W'(s1_lvl_r[d]);
      end
      out_valid_r  <= s2_valid_r;
      out_sample_r <= s2_valid_r ? clamp_s : ZERO_CODE;
    end
  end

  // Dimension sum, floor shift, offset and saturation to the DAC range
  always_comb begin
    sum_s = '0;
    for (int d = 0; d < NUM_DIM; d++) sum_s = sum_s + SUM_W'(s2_prod_r[d]);
    shift_s  = sum_s >>> OUT_SHIFT;
    biased_s = OFS_W'(shift_s) + OFS_ZERO;
    if (biased_s[OFS_W-1])       clamp_s = '0;
    else if (biased_s > OFS_MAX) clamp_s = '1;
    else                         clamp_s = biased_s[DAC_WIDTH-1:0];
  end

  assign bus.sym_ready  = ~hold_full_r;
  assign bus.out_sample = out_sample_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.underrun   = underrun_r;
endmodule

// File: tb/tb_basis_modulator_nd.sv
// Scoreboard bench for basis_modulator_nd: directed symbols push hand-computed
// samples into a queue that a negedge monitor pops whenever out_valid is high.
`timescale 1ns/1ps
module tb_basis_modulator_nd;
  localparam int NUM_DIM = 3, AMP_WIDTH = 2, SPS = 10, IDX_WIDTH = 4;
  localparam int COEF_WIDTH = 12, DAC_WIDTH = 12, OUT_SHIFT = 2, ZERO_OFFSET = 2048;
  localparam int DSEL_W = 2;
  localparam int SYM_W = NUM_DIM * AMP_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  basis_modulator_nd_if #(.NUM_DIM(NUM_DIM), .AMP_WIDTH(AMP_WIDTH), .IDX_WIDTH(IDX_WIDTH),
                          .COEF_WIDTH(COEF_WIDTH), .DAC_WIDTH(DAC_WIDTH)) bus ();

  basis_modulator_nd #(.NUM_DIM(NUM_DIM), .AMP_WIDTH(AMP_WIDTH), .SPS(SPS), .IDX_WIDTH(IDX_WIDTH),
                       .COEF_WIDTH(COEF_WIDTH), .DAC_WIDTH(DAC_WIDTH), .OUT_SHIFT(OUT_SHIFT),
                       .ZERO_OFFSET(ZERO_OFFSET)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sb_q[$];
  int run_len = 0;
  int max_run = 0;
  int mon_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid output sample is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_unexpected: got %0d expected none", bus.out_sample);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sample", bus.out_sample, mon_exp);
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic push_const(input int v);
    for (int i = 0; i < SPS; i++) sb_q.push_back(v);
  endtask

  task automatic write_coef(input int d, input int a, input int v);
    bus.coef_we    = 1'b1;
    bus.coef_dim   = DSEL_W'(d);
    bus.coef_addr  = IDX_WIDTH'(a);
    bus.coef_wdata = COEF_WIDTH'(v);
    @(posedge clk); #1;
    bus.coef_we    = 1'b0;
  endtask

  task automatic load_dim(input int d, input int v);
    for (int a = 0; a < SPS; a++) write_coef(d, a, v);
  endtask

  // Offer a symbol and return 1ns after the edge that accepted it
  task automatic send_sym(input logic [SYM_W-1:0] d);
    int n = 0;
    bus.sym_valid = 1'b1;
    bus.sym_data  = d;
    while (n < 200) begin
      @(negedge clk);
      if (bus.sym_ready) break;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no sym_ready expected accept");
    end
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (!bus.out_valid && sb_q.size() == 0) break;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.sym_valid    = 1'b0;
    bus.sym_data     = '0;
    bus.coef_we      = 1'b0;
    bus.coef_dim     = '0;
    bus.coef_addr    = '0;
    bus.coef_wdata   = '0;
    bus.underrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", bus.out_sample, 2048);
    check("rst_sym_ready", bus.sym_ready, 1);
    check("rst_underrun", bus.underrun, 0);
    @(posedge clk); #1;

    // dim0 = 100 everywhere, other dims silent
    load_dim(0, 100);
    load_dim(1, 0);
    load_dim(2, 0);

    push_const(2123);
    send_sym(6'b00_00_11);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("latency_valid", bus.out_valid, (k == 4) ? 1 : 0);
    end
    wait_drain();
    check("idle_out_sample", bus.out_sample, 2048);
    check("idle_out_valid", bus.out_valid, 0);
    check("underrun_set", bus.underrun, 1);
    bus.underrun_clr = 1'b1;
    @(posedge clk); #1;
    bus.underrun_clr = 1'b0;
    check("underrun_clr", bus.underrun, 0);

    // Clear pulse lands on the same edge that sets underrun
    push_const(1973);
    send_sym(6'b00_00_00);
    repeat (9) @(posedge clk);
    #1 bus.underrun_clr = 1'b1;
    @(posedge clk); #1;
    bus.underrun_clr = 1'b0;
    check("underrun_set_wins", bus.underrun, 1);
    wait_drain();

    // Reset in the middle of a symbol at idx 5
    push_const(2123);
    send_sym(6'b00_00_11);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sym_ready", bus.sym_ready, 1);
    check("midrst_out_sample", bus.out_sample, 2048);
    check("midrst_underrun", bus.underrun, 0);
    push_const(2123);
    send_sym(6'b00_00_11);
    wait_drain();

    // Rewrite coef[0][3] while idx is 1; out-of-range writes must not land
    for (int i = 0; i < SPS; i++) sb_q.push_back((i == 3) ? 2198 : 2123);
    send_sym(6'b00_00_11);
    write_coef(0, 3, 200);
    write_coef(0, 12, 999);
    write_coef(3, 0, 999);
    wait_drain();

    // Mixed dimensions, back-to-back burst of five symbols
    load_dim(0, 100);
    load_dim(1, 40);
    load_dim(2, -21);
    max_run = 0;
    for (int s = 0; s < 5; s++) begin
      if (s % 2 == 0) begin
        push_const(2107);
        send_sym(6'b10_01_11);
      end else begin
        push_const(1998);
        send_sym(6'b00_10_00);
      end
      if (s == 1) check("hold_full_ready", bus.sym_ready, 0);
    end
    wait_drain();
    check("burst_continuous", max_run, 50);

    // Saturation at both rails
    load_dim(0, 2047);
    load_dim(1, 2047);
    load_dim(2, 2047);
    push_const(4095);
    send_sym(6'b11_11_11);
    wait_drain();
    push_const(0);
    send_sym(6'b00_00_00);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/basis_modulator_nd.md
Name: basis_modulator_nd

Overview:
N-dimensional basis-waveform modulator, the parametrised successor to the fixed 3-dimension modulator. It accepts one symbol per valid/ready handshake. Each dimension carries a multi-level antipodal amplitude code that scales a run-time-loadable basis table. The scaled dimensions are summed, offset and saturated into an unsigned DAC sample stream. A one-deep holding register allows back-to-back symbols without gaps, and underruns are flagged.

Parameters:
NUM_DIM, 3, number of basis dimensions
AMP_WIDTH, 2, amplitude code bits per dimension
SPS, 10, samples per symbol (>=2)
IDX_WIDTH, 4, sample index width, >= clog2(SPS)
COEF_WIDTH, 12, signed basis coefficient width
DAC_WIDTH, 12, unsigned output width
OUT_SHIFT, 2, arithmetic right shift applied to the dimension sum
ZERO_OFFSET, 2048, output code for zero signal

Ports:
clk  in  1  clock
rst  in  1  reset
sym_valid  in  1  symbol offered
sym_ready  out  1  symbol can be accepted
sym_data  in  NUM_DIM*AMP_WIDTH  codes; dim d at [d*AMP_WIDTH +: AMP_WIDTH]
coef_we  in  1  basis table write strobe
coef_dim  in  clog2(NUM_DIM) (min 1)  table select
coef_addr  in  IDX_WIDTH  sample index to write
coef_wdata  in  COEF_WIDTH  signed coefficient
out_sample  out  DAC_WIDTH  DAC code
out_valid  out  1  out_sample carries a modulated sample
underrun  out  1  sticky: symbol stream ran dry mid-stream
underrun_clr  in  1  clears underrun

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset values: state=IDLE, idx=0, hold empty, sym_ready=1, out_valid=0, out_sample=ZERO_OFFSET, underrun=0, pipeline valids=0. Basis tables are NOT cleared by reset.
- Accept = sym_valid & sym_ready at the clk edge. sym_ready = !hold_full (registered state, no combinational path from sym_valid).
- FSM IDLE: on accept, load the symbol into cur, set idx=0, go to RUN. hold stays empty.
- FSM RUN: idx increments each cycle.
  - Accept while idx != SPS-1: store into hold.
  - At idx==SPS-1 with hold full: cur<=hold, hold empties, idx<=0, stay RUN (gapless).
  - At idx==SPS-1 with hold empty and an accept that same cycle: the symbol goes directly to cur, idx<=0, stay RUN.
  - At idx==SPS-1 with hold empty and no accept: go to IDLE and set underrun.
- underrun is sticky. underrun_clr clears it. If set and clear coincide, set wins.
- Amplitude mapping: code k -> signed level L = 2k-(2^AMP_WIDTH-1). For AMP_WIDTH=2: 0,1,2,3 -> -3,-1,+1,+3.
- Pipeline (stage tag travels with data):
  - S1: register coef[d][idx] for all d.
  - S2: register p_d = coef*L (signed, COEF_WIDTH+AMP_WIDTH+1 bits).
  - S3: sum all p_d at full width (+clog2(NUM_DIM) bits), arithmetic shift right by OUT_SHIFT, add ZERO_OFFSET, clamp to [0, 2^DAC_WIDTH-1], register out_sample.
- Latency: a symbol accepted from IDLE at edge t gives idx=0 from t+1. Sample 0 appears at out_valid/out_sample after edge t+4. Each symbol yields exactly SPS consecutive valid samples.
- After the last sample drains, out_valid=0 and out_sample returns to ZERO_OFFSET.
- Coefficient writes are allowed in any state. The new value is seen by the first S1 read after the write edge. A write and a read of the same address in the same cycle returns the old value.
- Writes with coef_dim >= NUM_DIM or coef_addr >= SPS are ignored.
- rst mid-symbol aborts immediately. Outputs take reset values on the next edge, and partial samples are discarded.

Test Plan:
- Load dim0 table = 100 at all indices, other dims = 0. Send code 3 on dim0, 0-level elsewhere impossible, so use NUM_DIM=1 config -> out 2123 for 10 cycles, first valid 4 cycles after accept. Code 0 -> 1973.
- Default config, all tables = 2047, all codes 3 -> sum 18423, >>2 = 4605, +2048 -> clamps to 4095. All codes 0 -> clamps to 0.
- sym_valid held high with 5 symbols -> out_valid continuous for 50 cycles. sym_ready low while hold is full. No gap between symbols.
- Single symbol then sym_valid=0 -> 10 valid samples, then out_valid=0, out_sample=2048, underrun=1. underrun_clr pulse -> 0. Simultaneous set and clear -> 1.
- Assert rst at idx=5 -> next cycle out_valid=0, sym_ready=1, out_sample=2048. Tables are retained, so the next symbol reproduces the earlier waveform.
- Rewrite coef[0][3] while RUN at idx=1 -> the current symbol's sample 3 uses the new value. Out-of-range coef_addr=12 is ignored.
